// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard-unit signal bundle: pipeline register indices and status flags in,
// stall/flush/forward controls out. The pipeline side uses master, the hazard
// unit uses slave.
interface riscv_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] Rs1D;
    logic [REG_W-1:0] Rs2D;
    logic [REG_W-1:0] Rs1E;
    logic [REG_W-1:0] Rs2E;
    logic [REG_W-1:0] RdE;
    logic             PCSrcE;
    logic             ResultSrcE_zero;
    logic             MulDivE;
    logic [REG_W-1:0] RdM;
    logic             RegWriteM;
    logic [REG_W-1:0] RdW;
    logic             RegWriteW;
    logic             IMemReadyF;
    logic             DMemReqM;
    logic             DMemReadyM;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MulDivBusy;
    logic             MemErr;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, PCSrcE, ResultSrcE_zero, MulDivE,
               RdM, RegWriteM, RdW, RegWriteW, IMemReadyF, DMemReqM, DMemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, MulDivBusy, MemErr
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, PCSrcE, ResultSrcE_zero, MulDivE,
               RdM, RegWriteM, RdW, RegWriteW, IMemReadyF, DMemReqM, DMemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, MulDivBusy, MemErr
    );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Hazard control for a 5-stage RISC-V pipeline: operand forwarding, load-use
// stalls, branch flushes, multi-cycle execute occupancy and data-memory wait
// freezing with a sticky timeout error.
module riscv_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int MULDIV_LAT   = 4,
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    riscv_hazard_ctrl_if.slave    hz
);
    localparam int CNT_W  = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    localparam int WCNT_W = (DMEM_TIMEOUT > 0) ? $clog2(DMEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MULDIV_LAT - 2);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(DMEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);
    localparam logic [REG_W-1:0]  X0        = '0;
    localparam bit                TO_EN     = (DMEM_TIMEOUT != 0);

    typedef enum logic [1:0] {S_RUN, S_MD_BUSY, S_ERR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              r_mdbusy;
    logic              r_memerr;

    logic w_wait;
    logic w_freeze;
    logic w_md;
    logic w_lw;
    logic w_timeout;

    // Forward from the youngest in-flight writer; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rdm,
        input logic             wm,
        input logic [REG_W-1:0] rdw,
        input logic             ww
    );
        if (wm && rdm == rs && rs != X0)      return 2'b10;
        else if (ww && rdw == rs && rs != X0) return 2'b01;
        else                                  return 2'b00;
    endfunction

    // Hazard terms: a memory wait or error freezes everything; the multi-cycle
    // op and the load-use bubble only apply when the pipe is not frozen.
    always_comb begin
        w_wait    = hz.DMemReqM & ~hz.DMemReadyM;
        w_freeze  = (r_state == S_ERR) | w_wait;
        w_md      = ~w_freeze & (((r_state == S_RUN) & hz.MulDivE) |
                                 ((r_state == S_MD_BUSY) & (r_cnt != '0)));
        w_lw      = ~w_freeze & ~w_md & hz.ResultSrcE_zero & (hz.RdE != X0) &
                    ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
        w_timeout = TO_EN & w_wait & (r_wcnt == WCNT_LAST) & (r_state != S_ERR);
    end

    // Next state: freeze holds the multi-cycle sequence; a timeout overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_freeze) begin
            case (r_state)
                S_RUN: begin
                    if (hz.MulDivE) begin
                        w_state_nxt = S_MD_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                S_MD_BUSY: begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                    else             w_state_nxt = S_RUN;
                end
                default: ;
            endcase
        end
        if (w_timeout) w_state_nxt = S_ERR;

        w_wcnt_nxt = r_wcnt;
        if (!w_wait)                                       w_wcnt_nxt = '0;
        else if (r_state != S_ERR && r_wcnt != WCNT_MAX)   w_wcnt_nxt = r_wcnt + WCNT_W'(1);
    end

    // State, counters and registered status flags; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_wcnt   <= '0;
            r_mdbusy <= 1'b0;
            r_memerr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_mdbusy <= (w_state_nxt == S_MD_BUSY);
            r_memerr <= (w_state_nxt == S_ERR);
        end
    end

    // Stage controls: a load-use stall keeps D held even on a fetch miss.
    always_comb begin
        hz.StallF     = w_freeze | w_md | w_lw | ~hz.IMemReadyF;
        hz.StallD     = w_freeze | w_md | w_lw;
        hz.StallE     = w_freeze | w_md;
        hz.StallM     = w_freeze;
        hz.FlushW     = w_freeze;
        hz.FlushM     = w_md;
        hz.FlushE     = ~w_freeze & ~w_md & (w_lw | hz.PCSrcE);
        hz.FlushD     = ~w_freeze & ~w_md & (hz.PCSrcE | (~w_lw & ~hz.IMemReadyF));
        hz.MulDivBusy = r_mdbusy;
        hz.MemErr     = r_memerr;
    end

    // Operand forwarding is purely a function of register indices.
    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    end
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: two instances (timeout 8 and 4) share stimulus.
module tb_riscv_hazard_ctrl;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic PCSrcE, ResultSrcE_zero, MulDivE, RegWriteM, RegWriteW;
    logic IMemReadyF, DMemReqM, DMemReadyM;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_hazard_ctrl_if #(.REG_W(5)) ifa ();
    riscv_hazard_ctrl_if #(.REG_W(5)) ifb ();

    riscv_hazard_ctrl #(.REG_W(5), .MULDIV_LAT(LAT), .DMEM_TIMEOUT(8)) dut_a (
        .clk(clk), .clr(clr), .hz(ifa.slave));
    riscv_hazard_ctrl #(.REG_W(5), .MULDIV_LAT(LAT), .DMEM_TIMEOUT(4)) dut_b (
        .clk(clk), .clr(clr), .hz(ifb.slave));

    assign ifa.Rs1D = Rs1D;  assign ifb.Rs1D = Rs1D;
    assign ifa.Rs2D = Rs2D;  assign ifb.Rs2D = Rs2D;
    assign ifa.Rs1E = Rs1E;  assign ifb.Rs1E = Rs1E;
    assign ifa.Rs2E = Rs2E;  assign ifb.Rs2E = Rs2E;
    assign ifa.RdE  = RdE;   assign ifb.RdE  = RdE;
    assign ifa.RdM  = RdM;   assign ifb.RdM  = RdM;
    assign ifa.RdW  = RdW;   assign ifb.RdW  = RdW;
    assign ifa.PCSrcE = PCSrcE;                   assign ifb.PCSrcE = PCSrcE;
    assign ifa.ResultSrcE_zero = ResultSrcE_zero; assign ifb.ResultSrcE_zero = ResultSrcE_zero;
    assign ifa.MulDivE = MulDivE;                 assign ifb.MulDivE = MulDivE;
    assign ifa.RegWriteM = RegWriteM;             assign ifb.RegWriteM = RegWriteM;
    assign ifa.RegWriteW = RegWriteW;             assign ifb.RegWriteW = RegWriteW;
    assign ifa.IMemReadyF = IMemReadyF;           assign ifb.IMemReadyF = IMemReadyF;
    assign ifa.DMemReqM = DMemReqM;               assign ifb.DMemReqM = DMemReqM;
    assign ifa.DMemReadyM = DMemReadyM;           assign ifb.DMemReadyM = DMemReadyM;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,FwdA,FwdB,Busy,MemErr}
    logic [13:0] obs_a, obs_b;
    assign obs_a = {ifa.StallF, ifa.StallD, ifa.StallE, ifa.StallM, ifa.FlushD, ifa.FlushE,
                    ifa.FlushM, ifa.FlushW, ifa.ForwardAE, ifa.ForwardBE, ifa.MulDivBusy, ifa.MemErr};
    assign obs_b = {ifb.StallF, ifb.StallD, ifb.StallE, ifb.StallM, ifb.FlushD, ifb.FlushE,
                    ifb.FlushM, ifb.FlushW, ifb.ForwardAE, ifb.ForwardBE, ifb.MulDivBusy, ifb.MemErr};

    function automatic logic [13:0] pk(input logic sf, sd, se, sm, fd, fe, fm, fw,
                                       input logic [1:0] fa, fb, input logic bz, er);
        return {sf, sd, se, sm, fd, fe, fm, fw, fa, fb, bz, er};
    endfunction

    // Reference model: E-stage occupancy count of the current multi-cycle op,
    // sticky error flag and a run-length of consecutive memory waits.
    int m_occ [2];
    bit m_err [2];
    int m_wc  [2];
    int m_to  [2] = '{8, 4};

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_out(input int k);
        bit wt  = DMemReqM && !DMemReadyM;
        bit fz  = m_err[k] || wt;
        int idx = (m_occ[k] > 0) ? m_occ[k] + 1 : (MulDivE ? 1 : 0);
        bit md  = !fz && idx != 0 && idx < LAT;
        bit lu  = ResultSrcE_zero && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        logic [7:0] sf;
        if (fz)      sf = 8'b1111_0001;
        else if (md) sf = 8'b1110_0010;
        else if (lu) sf = {2'b11, 2'b00, PCSrcE, 1'b1, 2'b00};
        else         sf = {!IMemReadyF, 3'b000, PCSrcE || !IMemReadyF, PCSrcE, 2'b00};
        return {sf, fwd_ref(Rs1E), fwd_ref(Rs2E), !m_err[k] && m_occ[k] > 0, m_err[k]};
    endfunction

    task automatic model_step(input int k);
        bit wt = DMemReqM && !DMemReadyM;
        bit fz = m_err[k] || wt;
        int idx;
        if (clr) begin
            m_occ[k] = 0; m_err[k] = 0; m_wc[k] = 0;
            return;
        end
        if (!fz) begin
            idx = (m_occ[k] > 0) ? m_occ[k] + 1 : (MulDivE ? 1 : 0);
            if (idx != 0) m_occ[k] = (idx < LAT) ? idx : 0;
        end
        if (!wt) m_wc[k] = 0;
        else if (!m_err[k]) begin
            m_wc[k]++;
            if (m_to[k] != 0 && m_wc[k] == m_to[k]) m_err[k] = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        PCSrcE = 0; ResultSrcE_zero = 0; MulDivE = 0; RegWriteM = 0; RegWriteW = 0;
        IMemReadyF = 1; DMemReqM = 0; DMemReadyM = 1;
    endtask

    task automatic do_clr();
        clr = 1; tick(); clr = 0;
    endtask

    task automatic test_reset();
        quiet(); clr = 1; tick(); #1;
        n_chk++; if (obs_a !== 14'd0) begin n_fail++; $display("FAIL reset_held_a got %b want %b", obs_a, 14'd0); end
        n_chk++; if (obs_b !== 14'd0) begin n_fail++; $display("FAIL reset_held_b got %b want %b", obs_b, 14'd0); end
        tick(); clr = 0; #1;
        n_chk++; if (obs_a !== 14'd0) begin n_fail++; $display("FAIL reset_rel_a got %b want %b", obs_a, 14'd0); end
        n_chk++; if (obs_b !== 14'd0) begin n_fail++; $display("FAIL reset_rel_b got %b want %b", obs_b, 14'd0); end
    endtask

    task automatic test_forwarding();
        quiet(); do_clr();
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; #1;
        n_chk++; if (ifa.ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_m_prio got %b want 10", ifa.ForwardAE); end
        RdM = 6; #1;
        n_chk++; if (ifa.ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_w got %b want 01", ifa.ForwardAE); end
        Rs1E = 0; #1;
        n_chk++; if (ifa.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_x0 got %b want 00", ifa.ForwardAE); end
        Rs2E = 6; RegWriteW = 0; #1;
        n_chk++; if (ifa.ForwardBE !== 2'b10) begin n_fail++; $display("FAIL fwdb_m got %b want 10", ifa.ForwardBE); end
        RegWriteM = 0; RegWriteW = 1; RdW = 6; DMemReqM = 1; DMemReadyM = 0; #1;
        n_chk++; if (ifa.ForwardBE !== 2'b01 || ifa.StallM !== 1'b1) begin
            n_fail++; $display("FAIL fwdb_frozen got %b/%b want 01/1", ifa.ForwardBE, ifa.StallM); end
        quiet(); #1;
    endtask

    task automatic test_load_use();
        quiet(); do_clr();
        ResultSrcE_zero = 1; RdE = 3; Rs2D = 3; #1;
        n_chk++; if (obs_a !== pk(1,1,0,0,0,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL lw_basic got %b want %b", obs_a, pk(1,1,0,0,0,1,0,0,0,0,0,0)); end
        IMemReadyF = 0; #1;
        n_chk++; if (obs_a !== pk(1,1,0,0,0,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL lw_imiss got %b want %b", obs_a, pk(1,1,0,0,0,1,0,0,0,0,0,0)); end
        IMemReadyF = 1; Rs2D = 0; Rs1D = 3; PCSrcE = 1; #1;
        n_chk++; if (obs_a !== pk(1,1,0,0,1,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL lw_branch got %b want %b", obs_a, pk(1,1,0,0,1,1,0,0,0,0,0,0)); end
        PCSrcE = 0; Rs1D = 0; Rs2D = 3; RdE = 0; #1;
        n_chk++; if (obs_a !== 14'd0) begin n_fail++; $display("FAIL lw_x0 got %b want %b", obs_a, 14'd0); end
        quiet(); #1;
    endtask

    task automatic test_branch_miss();
        quiet(); do_clr();
        PCSrcE = 1; IMemReadyF = 0; #1;
        n_chk++; if (obs_a !== pk(1,0,0,0,1,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL br_imiss got %b want %b", obs_a, pk(1,0,0,0,1,1,0,0,0,0,0,0)); end
        PCSrcE = 0; #1;
        n_chk++; if (obs_a !== pk(1,0,0,0,1,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL imiss_only got %b want %b", obs_a, pk(1,0,0,0,1,0,0,0,0,0,0,0)); end
        quiet(); #1;
    endtask

    task automatic test_muldiv();
        logic [13:0] e;
        quiet(); do_clr();
        MulDivE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            e = (i < 3) ? pk(1,1,1,0,0,0,1,0,0,0,i > 0,0) : pk(0,0,0,0,0,0,0,0,0,0,1,0);
            n_chk++; if (obs_a !== e) begin n_fail++; $display("FAIL muldiv_t%0d got %b want %b", i, obs_a, e); end
            tick();
        end
        MulDivE = 0; #1;
        n_chk++; if (obs_a !== 14'd0) begin n_fail++; $display("FAIL muldiv_done got %b want %b", obs_a, 14'd0); end
    endtask

    task automatic test_dmem_wait();
        logic [13:0] e;
        quiet(); do_clr();
        MulDivE = 1; tick(); MulDivE = 0; tick();
        DMemReqM = 1; DMemReadyM = 0;
        e = pk(1,1,1,1,0,0,0,1,0,0,1,0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (obs_a !== e) begin n_fail++; $display("FAIL wait_md_a%0d got %b want %b", i, obs_a, e); end
            n_chk++; if (obs_b !== e) begin n_fail++; $display("FAIL wait_md_b%0d got %b want %b", i, obs_b, e); end
            tick();
        end
        DMemReqM = 0; DMemReadyM = 1; #1;
        e = pk(1,1,1,0,0,0,1,0,0,0,1,0);
        n_chk++; if (obs_a !== e) begin n_fail++; $display("FAIL wait_resume got %b want %b", obs_a, e); end
        tick(); #1;
        e = pk(0,0,0,0,0,0,0,0,0,0,1,0);
        n_chk++; if (obs_a !== e) begin n_fail++; $display("FAIL wait_last got %b want %b", obs_a, e); end
        tick(); #1;
        n_chk++; if (obs_a !== 14'd0) begin n_fail++; $display("FAIL wait_run got %b want %b", obs_a, 14'd0); end
    endtask

    task automatic test_timeout();
        logic [13:0] e;
        quiet(); do_clr();
        DMemReqM = 1; DMemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (ifb.MemErr !== 1'b0) begin n_fail++; $display("FAIL to_early%0d got %b want 0", i, ifb.MemErr); end
            tick();
        end
        #1;
        n_chk++; if (ifb.MemErr !== 1'b1) begin n_fail++; $display("FAIL to_set got %b want 1", ifb.MemErr); end
        n_chk++; if (ifa.MemErr !== 1'b0) begin n_fail++; $display("FAIL to_a_noerr got %b want 0", ifa.MemErr); end
        DMemReqM = 0; DMemReadyM = 1; PCSrcE = 1; IMemReadyF = 0; MulDivE = 1;
        e = pk(1,1,1,1,0,0,0,1,0,0,0,1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (obs_b !== e) begin n_fail++; $display("FAIL err_hold%0d got %b want %b", i, obs_b, e); end
            tick();
        end
        quiet(); do_clr(); #1;
        n_chk++; if (obs_b !== 14'd0) begin n_fail++; $display("FAIL err_clr got %b want %b", obs_b, 14'd0); end
    endtask

    task automatic test_random();
        logic [13:0] e;
        int burst = 0;
        quiet(); do_clr();
        for (int k = 0; k < 2; k++) begin m_occ[k] = 0; m_err[k] = 0; m_wc[k] = 0; end
        for (int c = 0; c < 3000; c++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = $urandom_range(0, 1) == 1; RegWriteW = $urandom_range(0, 1) == 1;
            PCSrcE = $urandom_range(0, 5) == 0; ResultSrcE_zero = $urandom_range(0, 3) == 0;
            MulDivE = $urandom_range(0, 7) == 0; IMemReadyF = $urandom_range(0, 4) != 0;
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(2, 10);
            if (burst > 0) begin DMemReqM = 1; DMemReadyM = 0; burst--; end
            else begin DMemReqM = $urandom_range(0, 2) == 0; DMemReadyM = $urandom_range(0, 1) == 1; end
            clr = $urandom_range(0, 59) == 0;
            #1;
            e = model_out(0);
            n_chk++; if (obs_a !== e) begin n_fail++; $display("FAIL rand_a c%0d got %b want %b", c, obs_a, e); end
            e = model_out(1);
            n_chk++; if (obs_b !== e) begin n_fail++; $display("FAIL rand_b c%0d got %b want %b", c, obs_b, e); end
            @(posedge clk);
            model_step(0); model_step(1);
            #1;
        end
        clr = 0;
    endtask

    initial begin
        quiet();
        @(posedge clk); #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_miss();
        test_muldiv();
        test_dmem_wait();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
